// File: rtl/twiddle_mul.sv
// ---------------------------------------------------------------------------
// twiddle_mul -- radix-2 FFT stage twiddle multiplier, NUM lanes per beat.
//
// Each beat carries NUM butterfly outputs. The sum path (do1) is delayed and
// passed through. The difference path (do2) is multiplied by the twiddle
// W(k) = cos(2*pi*k/DATA) - j*sin(2*pi*k/DATA) in Q2.7, then rounded and
// saturated. The twiddle index of lane L is k = blk_cnt*NUM + L, where
// blk_cnt counts valid beats within a frame of DATA/(2*NUM) beats.
//
// Ports
//   clk                    rising-edge clock
//   rst                    synchronous active-high reset
//   do1_re/do1_im [NUM]    butterfly sum, signed IN_WIDTH
//   do2_re/do2_im [NUM]    butterfly difference, signed IN_WIDTH
//   valid_in               input beat valid (no backpressure)
//   dout1_re/dout1_im      sum path, sign-extended to OUT_WIDTH
//   dout2_re/dout2_im      difference path times twiddle, OUT_WIDTH
//   valid_out              valid_in delayed by 3 cycles
//   frame_last             last beat of a frame (qualified by valid_out)
//
// Pipeline: stage 1 registers inputs and twiddles, stage 2 the four
// partial products, stage 3 the add/sub, rounding and saturation.
// ---------------------------------------------------------------------------
module twiddle_mul #(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 11,
    parameter int TW_WIDTH  = 9,
    parameter int NUM       = 16,
    parameter int DATA      = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  do1_re   [NUM],
    input  logic signed [IN_WIDTH-1:0]  do1_im   [NUM],
    input  logic signed [IN_WIDTH-1:0]  do2_re   [NUM],
    input  logic signed [IN_WIDTH-1:0]  do2_im   [NUM],
    input  logic                        valid_in,
    output logic signed [OUT_WIDTH-1:0] dout1_re [NUM],
    output logic signed [OUT_WIDTH-1:0] dout1_im [NUM],
    output logic signed [OUT_WIDTH-1:0] dout2_re [NUM],
    output logic signed [OUT_WIDTH-1:0] dout2_im [NUM],
    output logic                        valid_out,
    output logic                        frame_last
);

    localparam int NBLK    = DATA / (2 * NUM);
    localparam int CW      = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int NTW     = DATA / 2;
    localparam int TW_FRAC = TW_WIDTH - 2;
    localparam int PW      = IN_WIDTH + TW_WIDTH;  // full product width
    localparam int SW      = PW + 2;               // sum plus rounding headroom

    localparam logic [CW-1:0]        BLK_LAST = CW'(NBLK - 1);
    localparam logic signed [SW-1:0] RND      = SW'(1 << (TW_FRAC - 1));
    localparam logic signed [SW-1:0] SAT_HI   = SW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO   = ~SAT_HI;

    // Twiddle tables are elaboration-time constants, packed TW_WIDTH per entry.
    function automatic logic [NTW*TW_WIDTH-1:0] gen_rom(input bit imag);
        logic [NTW*TW_WIDTH-1:0] rom;
        real                     ang;
        real                     v;
        int                      q;
        rom = '0;
        for (int k = 0; k < NTW; k++) begin
            ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(DATA);
            v   = imag ? -real'(1 << TW_FRAC) * $sin(ang)
                       :  real'(1 << TW_FRAC) * $cos(ang);
            q   = int'(v);  // real-to-int cast rounds half away from zero
            rom[k*TW_WIDTH +: TW_WIDTH] = q[TW_WIDTH-1:0];
        end
        return rom;
    endfunction

    localparam logic [NTW*TW_WIDTH-1:0] TW_RE_ROM = gen_rom(1'b0);
    localparam logic [NTW*TW_WIDTH-1:0] TW_IM_ROM = gen_rom(1'b1);

    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [SW-1:0] x);
        if (x > SAT_HI)      return SAT_HI[OUT_WIDTH-1:0];
        else if (x < SAT_LO) return SAT_LO[OUT_WIDTH-1:0];
        else                 return x[OUT_WIDTH-1:0];
    endfunction

    // Beat counter and stage 1
    logic [CW-1:0]              blk_cnt_q, blk_cnt_d;
    logic                       s1_valid_q, s1_last_q;
    logic signed [IN_WIDTH-1:0] s1_a_re_q [NUM], s1_a_im_q [NUM];
    logic signed [IN_WIDTH-1:0] s1_b_re_q [NUM], s1_b_im_q [NUM];
    logic signed [TW_WIDTH-1:0] s1_tw_re_q [NUM], s1_tw_im_q [NUM];
    logic signed [TW_WIDTH-1:0] tw_re_d [NUM], tw_im_d [NUM];

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (valid_in) blk_cnt_d = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + 1'b1;
        for (int l = 0; l < NUM; l++) begin
            tw_re_d[l] = TW_RE_ROM[(int'(blk_cnt_q) * NUM + l) * TW_WIDTH +: TW_WIDTH];
            tw_im_d[l] = TW_IM_ROM[(int'(blk_cnt_q) * NUM + l) * TW_WIDTH +: TW_WIDTH];
        end
    end

    // NOTE: state is written with <= so every block samples pre-edge values.
    // NOTE: data registers are cleared too, since the outputs must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            for (int l = 0; l < NUM; l++) begin
                s1_a_re_q[l]  <= '0;
                s1_a_im_q[l]  <= '0;
                s1_b_re_q[l]  <= '0;
                s1_b_im_q[l]  <= '0;
                s1_tw_re_q[l] <= '0;
                s1_tw_im_q[l] <= '0;
            end
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            s1_valid_q <= valid_in;
            s1_last_q  <= valid_in && (blk_cnt_q == BLK_LAST);
            if (valid_in) begin
                for (int l = 0; l < NUM; l++) begin
                    s1_a_re_q[l]  <= do1_re[l];
                    s1_a_im_q[l]  <= do1_im[l];
                    s1_b_re_q[l]  <= do2_re[l];
                    s1_b_im_q[l]  <= do2_im[l];
                    s1_tw_re_q[l] <= tw_re_d[l];
                    s1_tw_im_q[l] <= tw_im_d[l];
                end
            end
        end
    end

    // Stage 2: partial products
    logic                       s2_valid_q, s2_last_q;
    logic signed [IN_WIDTH-1:0] s2_a_re_q [NUM], s2_a_im_q [NUM];
    logic signed [PW-1:0]       s2_rr_q [NUM], s2_ii_q [NUM], s2_ri_q [NUM], s2_ir_q [NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            for (int l = 0; l < NUM; l++) begin
                s2_a_re_q[l] <= '0;
                s2_a_im_q[l] <= '0;
                s2_rr_q[l]   <= '0;
                s2_ii_q[l]   <= '0;
                s2_ri_q[l]   <= '0;
                s2_ir_q[l]   <= '0;
            end
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            if (s1_valid_q) begin
                for (int l = 0; l < NUM; l++) begin
                    s2_a_re_q[l] <= s1_a_re_q[l];
                    s2_a_im_q[l] <= s1_a_im_q[l];
                    s2_rr_q[l]   <= PW'(s1_b_re_q[l]) * PW'(s1_tw_re_q[l]);
                    s2_ii_q[l]   <= PW'(s1_b_im_q[l]) * PW'(s1_tw_im_q[l]);
                    s2_ri_q[l]   <= PW'(s1_b_re_q[l]) * PW'(s1_tw_im_q[l]);
                    s2_ir_q[l]   <= PW'(s1_b_im_q[l]) * PW'(s1_tw_re_q[l]);
                end
            end
        end
    end

    // Stage 3: complex add/sub, round half toward +inf, saturate
    logic                        valid_q, last_q;
    logic signed [OUT_WIDTH-1:0] dout1_re_q [NUM], dout1_im_q [NUM];
    logic signed [OUT_WIDTH-1:0] dout2_re_q [NUM], dout2_im_q [NUM];
    logic signed [OUT_WIDTH-1:0] dout2_re_d [NUM], dout2_im_d [NUM];

    always_comb begin
        logic signed [SW-1:0] re_sum;
        logic signed [SW-1:0] im_sum;
        re_sum = '0;
        im_sum = '0;
        for (int l = 0; l < NUM; l++) begin
            re_sum        = SW'(s2_rr_q[l]) - SW'(s2_ii_q[l]) + RND;
            im_sum        = SW'(s2_ri_q[l]) + SW'(s2_ir_q[l]) + RND;
            dout2_re_d[l] = sat(re_sum >>> TW_FRAC);
            dout2_im_d[l] = sat(im_sum >>> TW_FRAC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int l = 0; l < NUM; l++) begin
                dout1_re_q[l] <= '0;
                dout1_im_q[l] <= '0;
                dout2_re_q[l] <= '0;
                dout2_im_q[l] <= '0;
            end
        end else begin
            valid_q <= s2_valid_q;
            last_q  <= s2_valid_q && s2_last_q;
            // Outputs only move on valid beats and hold through gaps.
            if (s2_valid_q) begin
                for (int l = 0; l < NUM; l++) begin
                    dout1_re_q[l] <= OUT_WIDTH'(s2_a_re_q[l]);
                    dout1_im_q[l] <= OUT_WIDTH'(s2_a_im_q[l]);
                    dout2_re_q[l] <= dout2_re_d[l];
                    dout2_im_q[l] <= dout2_im_d[l];
                end
            end
        end
    end

    assign dout1_re   = dout1_re_q;
    assign dout1_im   = dout1_im_q;
    assign dout2_re   = dout2_re_q;
    assign dout2_im   = dout2_im_q;
    assign valid_out  = valid_q;
    assign frame_last = last_q;

endmodule

// File: tb/tb_twiddle_mul.sv
// ---------------------------------------------------------------------------
// tb_twiddle_mul -- self-checking bench for twiddle_mul (default parameters).
//
// A reference model computes each output beat from the input beat with real
// trigonometry and integer arithmetic, delays it by the pipeline latency and
// a compare process checks every output on every falling edge. Directed
// scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_twiddle_mul;

    localparam int IN_WIDTH  = 10;
    localparam int OUT_WIDTH = 11;
    localparam int TW_WIDTH  = 9;
    localparam int NUM       = 16;
    localparam int DATA      = 512;
    localparam int NBLK      = DATA / (2 * NUM);
    localparam real PI       = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_in = 1'b0;
    logic signed [IN_WIDTH-1:0]  do1_re [NUM], do1_im [NUM], do2_re [NUM], do2_im [NUM];
    logic signed [OUT_WIDTH-1:0] dout1_re [NUM], dout1_im [NUM], dout2_re [NUM], dout2_im [NUM];
    logic valid_out, frame_last;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    twiddle_mul #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .TW_WIDTH(TW_WIDTH),
        .NUM(NUM), .DATA(DATA)
    ) dut (
        .clk(clk), .rst(rst),
        .do1_re(do1_re), .do1_im(do1_im), .do2_re(do2_re), .do2_im(do2_im),
        .valid_in(valid_in),
        .dout1_re(dout1_re), .dout1_im(dout1_im),
        .dout2_re(dout2_re), .dout2_im(dout2_im),
        .valid_out(valid_out), .frame_last(frame_last)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int tw_re_m [DATA/2];
    int tw_im_m [DATA/2];

    function automatic int round_away(input real v);
        if (v >= 0.0) return int'($floor(v + 0.5));
        else          return -int'($floor(-v + 0.5));
    endfunction

    // Divide by 128 rounding half up, then clip to the output range.
    function automatic int scale_sat(input longint x);
        longint r;
        r = longint'($floor((real'(x) + 64.0) / 128.0));
        if (r > 1023)  r = 1023;
        if (r < -1024) r = -1024;
        return int'(r);
    endfunction

    task automatic cmul(input int ar, input int ai, input int k, output int pr, output int pi);
        longint re, im;
        re = longint'(ar) * tw_re_m[k] - longint'(ai) * tw_im_m[k];
        im = longint'(ar) * tw_im_m[k] + longint'(ai) * tw_re_m[k];
        pr = scale_sat(re);
        pi = scale_sat(im);
    endtask

    typedef struct {
        int     o1re [NUM];
        int     o1im [NUM];
        int     o2re [NUM];
        int     o2im [NUM];
        bit     last;
        longint due;
    } exp_t;

    exp_t   pend [$];
    exp_t   cur;
    exp_t   nb;
    bit     exp_valid = 1'b0;
    bit     exp_last  = 1'b0;
    bit     live      = 1'b0;
    int     m_blk     = 0;
    longint edge_n    = 0;

    always @(posedge clk) begin
        int pr, pi;
        edge_n++;
        if (rst) begin
            pend.delete();
            m_blk     = 0;
            exp_valid = 1'b0;
            exp_last  = 1'b0;
            for (int l = 0; l < NUM; l++) begin
                cur.o1re[l] = 0; cur.o1im[l] = 0; cur.o2re[l] = 0; cur.o2im[l] = 0;
            end
            live = 1'b1;
        end else begin
            if (valid_in) begin
                for (int l = 0; l < NUM; l++) begin
                    nb.o1re[l] = int'(do1_re[l]);
                    nb.o1im[l] = int'(do1_im[l]);
                    cmul(int'(do2_re[l]), int'(do2_im[l]), m_blk * NUM + l, pr, pi);
                    nb.o2re[l] = pr;
                    nb.o2im[l] = pi;
                end
                nb.last = (m_blk == NBLK - 1);
                nb.due  = edge_n + 2;
                pend.push_back(nb);
                m_blk = (m_blk + 1) % NBLK;
            end
            exp_valid = 1'b0;
            exp_last  = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                cur       = pend.pop_front();
                exp_valid = 1'b1;
                exp_last  = cur.last;
            end
        end
    end

    // ---------------- compare process ----------------
    int out_cnt = 0;
    int fl_pos [$];

    always @(negedge clk) begin
        if (live) begin
            check("valid_out", int'(valid_out), int'(exp_valid));
            check("frame_last", int'(frame_last), int'(exp_last));
            for (int l = 0; l < NUM; l++) begin
                check($sformatf("dout1_re[%0d]", l), int'(dout1_re[l]), cur.o1re[l]);
                check($sformatf("dout1_im[%0d]", l), int'(dout1_im[l]), cur.o1im[l]);
                check($sformatf("dout2_re[%0d]", l), int'(dout2_re[l]), cur.o2re[l]);
                check($sformatf("dout2_im[%0d]", l), int'(dout2_im[l]), cur.o2im[l]);
            end
            if (valid_out) begin
                out_cnt++;
                if (frame_last) fl_pos.push_back(out_cnt);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit v);
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int l = 0; l < NUM; l++) begin
            do1_re[l] = IN_WIDTH'($urandom);
            do1_im[l] = IN_WIDTH'($urandom);
            do2_re[l] = (l % 5 == 0) ? IN_WIDTH'(-512) : IN_WIDTH'($urandom);
            do2_im[l] = (l % 7 == 3) ? IN_WIDTH'(511)  : IN_WIDTH'($urandom);
        end
    endtask

    task automatic set_lane0(input int a_re, input int a_im, input int b_re, input int b_im);
        do1_re[0] = IN_WIDTH'(a_re);
        do1_im[0] = IN_WIDTH'(a_im);
        do2_re[0] = IN_WIDTH'(b_re);
        do2_im[0] = IN_WIDTH'(b_im);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int pr, pi;
        for (int k = 0; k < DATA/2; k++) begin
            tw_re_m[k] = round_away( 128.0 * $cos(2.0 * PI * real'(k) / real'(DATA)));
            tw_im_m[k] = round_away(-128.0 * $sin(2.0 * PI * real'(k) / real'(DATA)));
        end
        // Pin the model to hand-computed values.
        check("model tw_re[0]", tw_re_m[0], 128);
        check("model tw_im[0]", tw_im_m[0], 0);
        check("model tw_re[64]", tw_re_m[64], 91);
        check("model tw_im[64]", tw_im_m[64], -91);
        check("model tw_re[128]", tw_re_m[128], 0);
        check("model tw_im[128]", tw_im_m[128], -128);
        check("model tw_im[1]", tw_im_m[1], -2);
        cmul(-512, -512, 64, pr, pi);
        check("model k64 re", pr, -728);
        check("model k64 im", pi, 0);
        cmul(100, 50, 128, pr, pi);
        check("model k128 re", pr, 50);
        check("model k128 im", pi, -100);

        for (int l = 0; l < NUM; l++) begin
            do1_re[l] = '0; do1_im[l] = '0; do2_re[l] = '0; do2_im[l] = '0;
        end

        // Reset state
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        check("reset valid_out", int'(valid_out), 0);
        check("reset frame_last", int'(frame_last), 0);
        check("reset dout2_re[3]", int'(dout2_re[3]), 0);
        check("reset dout1_im[7]", int'(dout1_im[7]), 0);
        rst = 1'b0;

        // k=0: blk 0, lane 0
        fill();
        set_lane0(7, -3, 100, -50);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        check("k0 valid_out", int'(valid_out), 1);
        check("k0 dout2_re[0]", int'(dout2_re[0]), 100);
        check("k0 dout2_im[0]", int'(dout2_im[0]), -50);
        check("k0 dout1_re[0]", int'(dout1_re[0]), 7);
        check("k0 dout1_im[0]", int'(dout1_im[0]), -3);

        // blk 1..3, then k=64 at blk 4
        repeat (3) begin fill(); step(1'b1); end
        fill();
        set_lane0(0, 0, -512, -512);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        check("k64 dout2_re[0]", int'(dout2_re[0]), -728);
        check("k64 dout2_im[0]", int'(dout2_im[0]), 0);

        // blk 5..7, then k=128 at blk 8
        repeat (3) begin fill(); step(1'b1); end
        fill();
        set_lane0(1, 1, 100, 50);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        check("k128 dout2_re[0]", int'(dout2_re[0]), 50);
        check("k128 dout2_im[0]", int'(dout2_im[0]), -100);

        // blk 9..15 finishes the frame
        repeat (7) begin fill(); step(1'b1); end
        repeat (4) step(1'b0);

        // Frame streaming: 32 back-to-back beats
        out_cnt = 0;
        fl_pos.delete();
        repeat (32) begin fill(); step(1'b1); end
        repeat (4) step(1'b0);
        check("stream frame_last count", fl_pos.size(), 2);
        check("stream frame_last first", (fl_pos.size() > 0) ? fl_pos[0] : -1, 16);
        check("stream frame_last second", (fl_pos.size() > 1) ? fl_pos[1] : -1, 32);

        // Valid gaps: 5 beats, 3 idle, 11 beats
        out_cnt = 0;
        fl_pos.delete();
        repeat (5) begin fill(); step(1'b1); end
        repeat (3) step(1'b0);
        repeat (11) begin fill(); step(1'b1); end
        repeat (4) step(1'b0);
        check("gap frame_last count", fl_pos.size(), 1);
        check("gap frame_last pos", (fl_pos.size() > 0) ? fl_pos[0] : -1, 16);

        // Mid-frame reset after 6 beats; the beat coinciding with rst is dropped
        repeat (6) begin fill(); step(1'b1); end
        rst = 1'b1;
        fill();
        step(1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check("post-reset valid_out", int'(valid_out), 0);
        end
        for (int l = 0; l < NUM; l++) begin
            do1_re[l] = IN_WIDTH'(l);
            do1_im[l] = IN_WIDTH'(-l);
            do2_re[l] = IN_WIDTH'(100);
            do2_im[l] = '0;
        end
        step(1'b1);
        step(1'b0);
        step(1'b0);
        check("rst k=lane valid_out", int'(valid_out), 1);
        check("rst lane0 dout2_re", int'(dout2_re[0]), 100);
        check("rst lane0 dout2_im", int'(dout2_im[0]), 0);
        check("rst lane1 dout2_re", int'(dout2_re[1]), 100);
        check("rst lane1 dout2_im", int'(dout2_im[1]), -2);
        check("rst lane15 dout2_re", int'(dout2_re[15]), 98);
        check("rst lane15 dout2_im", int'(dout2_im[15]), -18);
        check("rst lane15 dout1_im", int'(dout1_im[15]), -15);
        repeat (3) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/twiddle_mul.md
TWIDDLE_MUL -- requirements
Module: twiddle_mul

Interface
REQ-001 The block SHALL have these parameters: IN_WIDTH, default 10, butterfly output width per component.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 11, output width per component.
REQ-003 The block SHALL have parameter TW_WIDTH, default 9, signed twiddle width, Q2.7 format where +1.0 = 128.
REQ-004 The block SHALL have parameter NUM, default 16, the number of parallel lanes.
REQ-005 The block SHALL have parameter DATA, default 512, the FFT size.
REQ-006 The block SHALL have these ports:
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  do1_re[NUM]  in  IN_WIDTH signed  butterfly sum, real part.
  do1_im[NUM]  in  IN_WIDTH signed  butterfly sum, imaginary part.
  do2_re[NUM]  in  IN_WIDTH signed  butterfly difference, real part.
  do2_im[NUM]  in  IN_WIDTH signed  butterfly difference, imaginary part.
  valid_in  in  1  input beat valid.
  dout1_re[NUM], dout1_im[NUM]  out  OUT_WIDTH signed  sum path, passed through.
  dout2_re[NUM], dout2_im[NUM]  out  OUT_WIDTH signed  difference path times twiddle.
  valid_out  out  1  output beat valid.
  frame_last  out  1  marks the last beat of a frame.

Function
REQ-007 The block SHALL accept one beat of NUM complex pairs per cycle whenever valid_in=1, with no backpressure.
REQ-008 The block SHALL hold a beat counter blk_cnt that runs 0..DATA/(2*NUM)-1 (0..15 at the defaults).
REQ-009 blk_cnt SHALL increment only on valid_in=1 and SHALL wrap from 15 to 0; a gap in valid_in SHALL not change blk_cnt.
REQ-010 Lane L of the beat with counter value blk_cnt SHALL use twiddle index k = blk_cnt*NUM + L, range 0..255.
REQ-011 The twiddle W(k) SHALL be a constant ROM inside the block: tw_re = round(128*cos(2*pi*k/DATA)), tw_im = round(-128*sin(2*pi*k/DATA)), with rounding half away from zero.
REQ-012 For each lane, dout2 SHALL equal (do2_re + j*do2_im) * (tw_re + j*tw_im), computed with full-precision products and sums (at least 20 bits).
REQ-013 Each product sum (real and imaginary) SHALL be scaled by adding 64 and then arithmetically shifting right by 7, which rounds half toward +infinity.
REQ-014 The scaled result SHALL then be saturated to the range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-015 dout1_re and dout1_im SHALL equal do1_re and do1_im sign-extended to OUT_WIDTH, delayed so they stay aligned with dout2.
REQ-016 The pipeline SHALL have 3 stages:
  stage 1: register the inputs and fetch the twiddle.
  stage 2: register the four products.
  stage 3: register the add/subtract, rounding and saturation.
REQ-017 valid_out SHALL equal valid_in delayed by exactly 3 cycles.
REQ-018 Outputs SHALL be updated only on beats where valid_out=1 and SHALL hold their last values otherwise.
REQ-019 frame_last SHALL be 1 only on the output beat that came from an input beat with blk_cnt=15, and only when valid_out=1.
REQ-020 Back-to-back frames SHALL stream with no bubble: the beat after blk_cnt=15 uses blk_cnt=0.

Reset
REQ-021 While rst=1 at a clock edge, the block SHALL clear blk_cnt, all valid pipeline bits, valid_out, frame_last, and every dout lane to 0.
REQ-022 A reset asserted mid-frame SHALL discard all in-flight beats: valid_out=0 in the 3 cycles after rst is released, unless new valid_in beats arrive.
REQ-023 After reset, the next valid_in beat SHALL use blk_cnt=0.
REQ-024 A valid_in beat present on the same cycle as rst=1 SHALL be ignored.

Verification
REQ-025 Scenario k=0: blk 0, lane 0, do2=(100,-50), do1=(7,-3) -> 3 cycles later dout2=(100,-50), dout1=(7,-3), valid_out=1.
REQ-026 Scenario k=128: blk 8, lane 0, do2=(100,50), twiddle=(0,-128) -> dout2=(50,-100).
REQ-027 Scenario k=64: blk 4, lane 0, do2=(-512,-512), twiddle=(91,-91) -> dout2=(-728,0), with no saturation.
REQ-028 Scenario frame streaming: 32 consecutive valid beats -> frame_last=1 exactly on output beats 16 and 32, and blk_cnt wraps with no gap.
REQ-029 Scenario valid gaps: 5 beats, 3 idle cycles, 11 beats -> frame_last on the 16th valid output, and outputs hold their values during the gap.
REQ-030 Scenario mid-frame reset: rst=1 for 1 cycle after 6 beats -> no valid_out for the in-flight beats, and the next beat uses k = lane index.
